core_data_port_arbiter: RTL and testbench
=========================================

Name: core_data_port_arbiter

Overview:
- Shares one single-ported data-memory request/grant/rvalid port between N_PORTS core data interfaces (riscv_core data_* style: req/gnt, then in-order rvalid).
- Round-robin arbitration on the request channel.
- Holds a lock on the selected requester until it is granted.
- Tracks outstanding transactions in an ID FIFO so each in-order response goes back to the requester that issued it.
- Sits between a cluster of cores and the shared memory/interconnect port.

Parameters:
N_PORTS, 4, number of requesting cores (≥2)
MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (power of 2, ≥1)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports:
Clock and reset: single clock clk_i; reset rst_i is asynchronous, active-high.
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  N_PORTS  per-core request
gnt_o  out  N_PORTS  per-core grant
rvalid_o  out  N_PORTS  per-core response valid
we_i  in  N_PORTS  per-core write enable
be_i  in  N_PORTS×DATA_WIDTH/8  per-core byte enables
addr_i  in  N_PORTS×ADDR_WIDTH  per-core address
wdata_i  in  N_PORTS×DATA_WIDTH  per-core write data
atop_i  in  N_PORTS×6  per-core atomic opcode
rdata_o  out  DATA_WIDTH  read data, broadcast to all cores; qualified by rvalid_o
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, mem_atop_o  out  as above  selected request payload
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory read data
busy_o  out  1  outstanding count ≠ 0
err_o  out  1  sticky: rvalid received with no transaction outstanding

Behaviour:
- Reset values:
  - rr_ptr=0, lock cleared, FIFO empty, count=0, err_o=0.
  - Hence busy_o=0, rvalid_o=0, mem_req_o=0 while all req_i=0.
- Selection:
  - If the lock is valid and req_i[lock_idx]=1, winner=lock_idx.
  - Otherwise winner = first set req_i bit searching from rr_ptr upward with wrap-around.
- Request path (combinational, zero latency):
  - mem_req_o = winner exists && count < MAX_OUTSTANDING.
  - Payload muxed from the winner.
  - gnt_o[winner] = mem_req_o && mem_gnt_i; all other gnt_o bits are 0.
- Handshake (mem_req_o && mem_gnt_i):
  - Push winner index into the FIFO; count+1.
  - rr_ptr ← (winner+1) mod N_PORTS.
  - Clear the lock.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, register lock_idx=winner, lock valid. Keeps the request stable under back-pressure.
  - If the locked requester drops req_i before being granted (protocol violation), the lock is released the next cycle and arbitration resumes. No grant is issued to it.
- Full condition:
  - count=MAX_OUTSTANDING blocks mem_req_o, even if mem_rvalid_i pops in the same cycle.
  - A pop frees the slot from the next cycle onward (no combinational rvalid→req path).
- Response path:
  - mem_rvalid_i with FIFO non-empty: rvalid_o[fifo_head]=1 in the same cycle, pop, count−1.
  - rdata_o=mem_rdata_i always.
  - mem_rvalid_i with FIFO empty: no rvalid_o, count unchanged, err_o←1 (sticky until reset).
- Simultaneous push and pop: count unchanged; FIFO order is preserved.
- Count arithmetic: width $clog2(MAX_OUTSTANDING+1). Never overflows (gated) or underflows (error path).
- Reset mid-operation: all state is cleared asynchronously; in-flight responses after reset set err_o.

Decomposition:
- Package core_arb_pkg:
  - port_idx_t (logic [$clog2(N_PORTS)-1:0]).
  - ATOP_WIDTH=6 constant.
  - function rr_select(req, ptr) returning the index and a found flag.
- Sub-module core_arb_id_fifo:
  - Parameterised DEPTH and data type.
  - push/pop/empty/full/head interface.
  - Pointer wrap via power-of-2 depth.
  - Contains all FIFO state.
- Top level: arbitration, lock, count and error logic.

Test Plan:
- Idle: after reset, drive no req_i → all outputs stay 0. Then req_i=0b0001 with mem_gnt_i=1 → gnt_o=0b0001 in the same cycle; rvalid 2 cycles later with rdata=0xDEADBEEF → rvalid_o=0b0001, rdata_o=0xDEADBEEF.
- Round-robin: req_i=0b1111 held, mem_gnt_i=1 every cycle, rvalid returned each cycle → grant order 0,1,2,3,0; rvalid_o follows the same order.
- Back-pressure/lock: req_i=0b0110, mem_gnt_i=0 for 3 cycles → mem_addr_o stable at port 1's address. Raise req_i[0] meanwhile → still port 1. Grant → gnt_o=0b0010; next grant goes to port 2.
- Full: MAX_OUTSTANDING=4; issue 4 granted requests with no rvalid → mem_req_o=0 and busy_o=1. One rvalid → mem_req_o rises on the following cycle, not the same one.
- Simultaneous push/pop at count=2: grant plus rvalid in the same cycle → count remains 2; responses return in issue order.
- Error and async reset: rvalid with FIFO empty → err_o=1, held. Assert rst_i mid-cycle with 3 outstanding → busy_o=0, err_o=0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/core_data_port_arbiter_pkg.sv
// Shared types and the round-robin search used by the core data-port arbiter.
package core_arb_pkg;

  localparam int unsigned N_PORTS_DEF = 4;
  localparam int unsigned ATOP_WIDTH  = 6;
  localparam int unsigned MAX_PORTS   = 32;
  localparam int unsigned MAX_IDX_W   = 5;

  typedef logic [$clog2(N_PORTS_DEF)-1:0] port_idx_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_result_t;

  // First set bit of req at or above ptr, wrapping at n (n <= MAX_PORTS, ptr < n).
  function automatic rr_result_t rr_select(input logic [MAX_PORTS-1:0] req,
                                           input logic [MAX_IDX_W-1:0] ptr,
                                           input int unsigned          n);
    rr_result_t  res;
    int unsigned j;
    res = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) begin
        j = j - n;
      end
      if ((i < n) && !res.found && req[j[MAX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = j[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/core_data_port_arbiter_if.sv
// Bundle of N parallel riscv-style data ports (req/gnt, in-order rvalid, shared rdata).
interface core_data_port_arbiter_if
  import core_arb_pkg::*;
#(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  localparam int unsigned BE_W = DW / 8;

  logic [N-1:0]                 req;
  logic [N-1:0]                 gnt;
  logic [N-1:0]                 rvalid;
  logic [N-1:0]                 we;
  logic [N-1:0][BE_W-1:0]       be;
  logic [N-1:0][AW-1:0]         addr;
  logic [N-1:0][DW-1:0]         wdata;
  logic [N-1:0][ATOP_WIDTH-1:0] atop;
  logic [DW-1:0]                rdata;

  modport master (
    output req, we, be, addr, wdata, atop,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata, atop,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/core_data_port_arbiter_id_fifo.sv
// Power-of-2 FIFO holding the requester index of each granted, unanswered transaction.
module core_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output logic empty_o,
  output logic full_o,
  output T     head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [IDX_W-1:0] widx_s;
  logic [IDX_W-1:0] ridx_s;
  logic             do_push_s;
  logic             do_pop_s;
  T                 mem_q [DEPTH];

  // The extra pointer bit distinguishes full from empty.
  generate
    if (DEPTH == 1) begin : g_single
      assign widx_s = 1'b0;
      assign ridx_s = 1'b0;
    end else begin : g_multi
      assign widx_s = wptr_q[IDX_W-1:0];
      assign ridx_s = rptr_q[IDX_W-1:0];
    end
  endgenerate

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = ((wptr_q - rptr_q) == PTR_W'(DEPTH));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[ridx_s];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= T'(1'b0);
      end
    end else begin
      if (do_push_s) begin
        mem_q[widx_s] <= data_i;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/core_data_port_arbiter.sv
// Round-robin arbiter sharing one single-ported data-memory port between N_PORTS cores,
// routing in-order responses back through a FIFO of requester indices.
module core_data_port_arbiter
  import core_arb_pkg::*;
#(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  core_data_port_arbiter_if.slave   cores,
  core_data_port_arbiter_if.master  mem,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t             LAST_IDX = idx_t'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic             lock_valid_q, lock_valid_d;
  idx_t             lock_idx_q,   lock_idx_d;
  idx_t             rr_ptr_q,     rr_ptr_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic             err_q,        err_d;

  logic [MAX_PORTS-1:0] req_ext_s;
  rr_result_t           rr_res_s;
  idx_t                 winner_s;
  logic                 found_s;
  logic                 mem_req_s;
  logic                 handshake_s;
  logic                 pop_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  idx_t                 fifo_head_s;
  logic [N_PORTS-1:0]   gnt_s;
  logic [N_PORTS-1:0]   rvalid_s;

  // Winner selection: a pending lock overrides the round-robin search.
  always_comb begin
    req_ext_s                = '0;
    req_ext_s[N_PORTS-1:0]   = cores.req;
    rr_res_s                 = rr_select(req_ext_s, MAX_IDX_W'(rr_ptr_q), N_PORTS);
    if (lock_valid_q && cores.req[lock_idx_q]) begin
      winner_s = lock_idx_q;
      found_s  = 1'b1;
    end else begin
      winner_s = idx_t'(rr_res_s.idx);
      found_s  = rr_res_s.found;
    end
  end

  // A full count blocks requests even when a response pops this cycle.
  assign mem_req_s   = found_s && (count_q < CNT_MAX) && !fifo_full_s;
  assign handshake_s = mem_req_s && mem.gnt[0];
  assign pop_s       = mem.rvalid[0] && !fifo_empty_s;

  // Grant and response steering back to the cores.
  always_comb begin
    if (handshake_s) begin
      gnt_s = N_PORTS'(1) << winner_s;
    end else begin
      gnt_s = '0;
    end
    if (pop_s) begin
      rvalid_s = N_PORTS'(1) << fifo_head_s;
    end else begin
      rvalid_s = '0;
    end
  end

  assign cores.gnt    = gnt_s;
  assign cores.rvalid = rvalid_s;
  assign cores.rdata  = mem.rdata;

  assign mem.req[0]   = mem_req_s;
  assign mem.we[0]    = cores.we[winner_s];
  assign mem.be[0]    = cores.be[winner_s];
  assign mem.addr[0]  = cores.addr[winner_s];
  assign mem.wdata[0] = cores.wdata[winner_s];
  assign mem.atop[0]  = cores.atop[winner_s];

  core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (idx_t)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (handshake_s),
    .data_i  (winner_s),
    .pop_i   (pop_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .head_o  (fifo_head_s)
  );

  // Next-state for lock, round-robin pointer, outstanding count and error flag.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_idx_d   = lock_idx_q;
    rr_ptr_d     = rr_ptr_q;
    count_d      = count_q;
    err_d        = err_q;

    if (handshake_s) begin
      lock_valid_d = 1'b0;
      if (winner_s == LAST_IDX) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = winner_s + idx_t'(1);
      end
    end else if (mem_req_s) begin
      lock_valid_d = 1'b1;
      lock_idx_d   = winner_s;
    end else if (lock_valid_q && !cores.req[lock_idx_q]) begin
      lock_valid_d = 1'b0;
    end else begin
      lock_valid_d = lock_valid_q;
    end

    case ({handshake_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (mem.rvalid[0] && fifo_empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_valid_q <= 1'b0;
      lock_idx_q   <= '0;
      rr_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_idx_q   <= lock_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_core_data_port_arbiter.sv
// Directed self-checking bench for core_data_port_arbiter (4 ports, 4 outstanding).
module tb_core_data_port_arbiter;

  logic clk;
  logic rst;
  logic busy;
  logic err;
  int   n_tests;
  int   n_fail;

  core_data_port_arbiter_if #(.N(4), .AW(32), .DW(32)) core_if ();
  core_data_port_arbiter_if #(.N(1), .AW(32), .DW(32)) mem_if ();

  core_data_port_arbiter #(
    .N_PORTS         (4),
    .MAX_OUTSTANDING (4),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cores  (core_if),
    .mem    (mem_if),
    .busy_o (busy),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] full_exp [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    core_if.req = 4'b0000;
    core_if.we  = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      core_if.be[p]    = 4'hF;
      core_if.addr[p]  = 32'h0000_1000 * (p + 1);
      core_if.wdata[p] = 32'hA000_0000 + p;
      core_if.atop[p]  = 6'd0;
    end
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = 32'h0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_memreq", mem_if.req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();

    // Idle and single transaction
    chk("idle_memreq", mem_if.req, 1'b0);
    chk("idle_gnt", core_if.gnt, 4'b0000);
    chk("idle_rvalid", core_if.rvalid, 4'b0000);
    core_if.req = 4'b0001;
    mem_if.gnt  = 1'b1;
    #1;
    chk("single_gnt", core_if.gnt, 4'b0001);
    chk("single_addr", mem_if.addr[0], 32'h0000_1000);
    tick();
    core_if.req = 4'b0000;
    mem_if.gnt  = 1'b0;
    #1;
    chk("single_busy", busy, 1'b1);
    tick();
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'hDEAD_BEEF;
    #1;
    chk("single_rvalid", core_if.rvalid, 4'b0001);
    chk("single_rdata", core_if.rdata, 32'hDEAD_BEEF);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("single_done_busy", busy, 1'b0);

    // Round-robin with a response every cycle, starting from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    core_if.req = 4'b1111;
    mem_if.gnt  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_if.rvalid = (k > 0) ? 1'b1 : 1'b0;
      #1;
      chk("rr_gnt", core_if.gnt, rr_exp[k]);
      if (k > 0) begin
        chk("rr_rvalid", core_if.rvalid, rr_exp[k-1]);
      end
      tick();
    end
    core_if.req   = 4'b0000;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    chk("rr_rvalid_last", core_if.rvalid, 4'b0001);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("rr_done_busy", busy, 1'b0);

    // Grant port 3 so the pointer wraps to 0
    core_if.req = 4'b1000;
    mem_if.gnt  = 1'b1;
    #1;
    chk("p3_gnt", core_if.gnt, 4'b1000);
    tick();
    core_if.req   = 4'b0000;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    chk("p3_rvalid", core_if.rvalid, 4'b1000);
    tick();
    mem_if.rvalid = 1'b0;

    // Back-pressure lock: port 1 must keep the port even when port 0 appears
    core_if.req = 4'b0110;
    #1;
    chk("lock_addr0", mem_if.addr[0], 32'h0000_2000);
    chk("lock_memreq", mem_if.req, 1'b1);
    chk("lock_gnt0", core_if.gnt, 4'b0000);
    tick();
    chk("lock_addr1", mem_if.addr[0], 32'h0000_2000);
    tick();
    core_if.req = 4'b0111;
    #1;
    chk("lock_hold_addr", mem_if.addr[0], 32'h0000_2000);
    tick();
    mem_if.gnt = 1'b1;
    #1;
    chk("lock_gnt", core_if.gnt, 4'b0010);
    tick();
    core_if.req = 4'b0101;
    #1;
    chk("lock_next_gnt", core_if.gnt, 4'b0100);
    tick();
    core_if.req   = 4'b0000;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    chk("lock_drain1", core_if.rvalid, 4'b0010);
    tick();
    chk("lock_drain2", core_if.rvalid, 4'b0100);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("lock_done_busy", busy, 1'b0);

    // Full: four grants, then blocked until the cycle after a pop
    core_if.req = 4'b1111;
    mem_if.gnt  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("full_fill_gnt", core_if.gnt, full_exp[k]);
      tick();
    end
    chk("full_memreq", mem_if.req, 1'b0);
    chk("full_gnt", core_if.gnt, 4'b0000);
    chk("full_busy", busy, 1'b1);
    mem_if.rvalid = 1'b1;
    #1;
    chk("full_pop_rvalid", core_if.rvalid, 4'b1000);
    chk("full_same_cycle_memreq", mem_if.req, 1'b0);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("full_reopen_memreq", mem_if.req, 1'b1);
    chk("full_reopen_gnt", core_if.gnt, 4'b1000);
    tick();
    core_if.req   = 4'b0000;
    mem_if.gnt    = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    chk("full_drain1", core_if.rvalid, 4'b0001);
    tick();
    chk("full_drain2", core_if.rvalid, 4'b0010);
    tick();

    // Simultaneous push and pop with two outstanding (ports 2,3)
    core_if.req = 4'b0001;
    mem_if.gnt  = 1'b1;
    #1;
    chk("sim_gnt", core_if.gnt, 4'b0001);
    chk("sim_rvalid", core_if.rvalid, 4'b0100);
    tick();
    core_if.req = 4'b0000;
    mem_if.gnt  = 1'b0;
    #1;
    chk("sim_order1", core_if.rvalid, 4'b1000);
    chk("sim_busy", busy, 1'b1);
    tick();
    chk("sim_order2", core_if.rvalid, 4'b0001);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("sim_done_busy", busy, 1'b0);

    // Response with nothing outstanding
    mem_if.rvalid = 1'b1;
    #1;
    chk("err_rvalid", core_if.rvalid, 4'b0000);
    chk("err_pre", err, 1'b0);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("err_set", err, 1'b1);
    tick();
    chk("err_held", err, 1'b1);
    chk("err_busy", busy, 1'b0);

    // Asynchronous reset with three outstanding
    core_if.req = 4'b1111;
    mem_if.gnt  = 1'b1;
    tick();
    tick();
    tick();
    core_if.req = 4'b0000;
    mem_if.gnt  = 1'b0;
    #1;
    chk("ar_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_err", err, 1'b0);
    rst = 1'b0;
    tick();
    mem_if.rvalid = 1'b1;
    #1;
    chk("ar_rvalid", core_if.rvalid, 4'b0000);
    tick();
    mem_if.rvalid = 1'b0;
    #1;
    chk("ar_err_after", err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
